instruction_memory_loader: RTL and testbench



---
 rtl/instruction_memory_loader_if.sv | 28 ++
 rtl/instruction_memory_loader.sv | 128 ++++++++++++
 tb/tb_instruction_memory_loader.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_memory_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader sits on the slave side; whoever feeds bytes and watches writes is the master.
interface instruction_memory_loader_if #(
  parameter int BYTE_WIDTH  = 8,
  parameter int WORD_WIDTH  = 32,
  parameter int ADDR_LENGTH = 32
);
  logic                   i_start;
  logic                   i_rx_done;
  logic [BYTE_WIDTH-1:0]  i_rx_data;
  logic                   o_wr_en;
  logic [ADDR_LENGTH-1:0] o_wr_addr;
  logic [WORD_WIDTH-1:0]  o_wr_data;
  logic                   o_busy;
  logic                   o_done;
  logic                   o_full;
  logic [ADDR_LENGTH-1:0] o_word_count;

  modport slave (
    input  i_start, i_rx_done, i_rx_data,
    output o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_full, o_word_count
  );

  modport master (
    output i_start, i_rx_done, i_rx_data,
    input  o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_full, o_word_count
  );
endinterface

// File: rtl/instruction_memory_loader.sv
// Packs a big-endian byte stream into instruction words and writes them to
// consecutive word addresses until the halt word arrives or memory is full.
module instruction_memory_loader #(
  parameter int                    MEM_SIZE    = 1024,
  parameter int                    WORD_WIDTH  = 32,
  parameter int                    ADDR_LENGTH = 32,
  parameter int                    BYTE_WIDTH  = 8,
  parameter logic [WORD_WIDTH-1:0] HALT_WORD   = 32'hFFFF_FFFF
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  instruction_memory_loader_if.slave   bus
);

  localparam int BYTES_PER_WORD = WORD_WIDTH / BYTE_WIDTH;
  localparam int CNT_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int SHIFT_W        = WORD_WIDTH - BYTE_WIDTH;
  localparam logic [CNT_W-1:0]       LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_LENGTH-1:0] LAST_ADDR = ADDR_LENGTH'(MEM_SIZE - 1);
  localparam logic [ADDR_LENGTH-1:0] MAX_COUNT = ADDR_LENGTH'(MEM_SIZE);

  typedef enum logic [1:0] {IDLE, RECEIVE, WRITE, DONE} state_t;

  state_t                 state_reg;
  logic [CNT_W-1:0]       byte_cnt_reg;
  logic [ADDR_LENGTH-1:0] addr_reg;
  logic [SHIFT_W-1:0]     shift_reg;
  logic                   wr_en_reg;
  logic [ADDR_LENGTH-1:0] wr_addr_reg;
  logic [WORD_WIDTH-1:0]  wr_data_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic                   full_reg;
  logic [ADDR_LENGTH-1:0] word_count_reg;
  logic [WORD_WIDTH-1:0]  word_next;

  // Only the bytes already received are kept; the incoming byte becomes lane 0
  // and every older byte moves one lane up, so the first byte ends up on top.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      if (gi == 0) begin : g_new
        assign word_next[BYTE_WIDTH-1:0] = bus.i_rx_data;
      end else begin : g_old
        assign word_next[gi*BYTE_WIDTH +: BYTE_WIDTH] = shift_reg[(gi-1)*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg      <= IDLE;
      byte_cnt_reg   <= '0;
      addr_reg       <= '0;
      shift_reg      <= '0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      full_reg       <= 1'b0;
      word_count_reg <= '0;
    end else begin
      wr_en_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (bus.i_start) begin
            state_reg      <= RECEIVE;
            byte_cnt_reg   <= '0;
            addr_reg       <= '0;
            shift_reg      <= '0;
            word_count_reg <= '0;
            full_reg       <= 1'b0;
            busy_reg       <= 1'b1;
            done_reg       <= 1'b0;
          end
        end
        RECEIVE: begin
          if (bus.i_rx_done) begin
            shift_reg <= word_next[SHIFT_W-1:0];
            if (byte_cnt_reg == LAST_BYTE) begin
              byte_cnt_reg <= '0;
              state_reg    <= WRITE;
              wr_en_reg    <= 1'b1;
              wr_addr_reg  <= addr_reg;
              wr_data_reg  <= word_next;
              if (word_count_reg != MAX_COUNT) begin
                word_count_reg <= word_count_reg + 1'b1;
              end
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 1'b1;
            end
          end
        end
        WRITE: begin
          // Halt takes priority over full: a halt in the last slot is a clean end.
          if (wr_data_reg == HALT_WORD) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else if (addr_reg == LAST_ADDR) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            full_reg  <= 1'b1;
          end else begin
            state_reg <= RECEIVE;
            addr_reg  <= addr_reg + 1'b1;
            if (bus.i_rx_done) begin
              shift_reg    <= word_next[SHIFT_W-1:0];
              byte_cnt_reg <= CNT_W'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.o_wr_en      = wr_en_reg;
  assign bus.o_wr_addr    = wr_addr_reg;
  assign bus.o_wr_data    = wr_data_reg;
  assign bus.o_busy       = busy_reg;
  assign bus.o_done       = done_reg;
  assign bus.o_full       = full_reg;
  assign bus.o_word_count = word_count_reg;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed-then-random bench for the instruction memory loader; expected writes
// come from regrouping the accepted byte list into words.
module tb_instruction_memory_loader;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_s;
  logic       rx_done_s;
  logic [7:0] rx_data_s;
  int         sel;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instruction_memory_loader_if #(.BYTE_WIDTH(8), .WORD_WIDTH(32), .ADDR_LENGTH(32)) bus ();
  instruction_memory_loader_if #(.BYTE_WIDTH(8), .WORD_WIDTH(32), .ADDR_LENGTH(32)) bus4 ();

  assign bus.i_start    = start_s && (sel == 0);
  assign bus.i_rx_done  = rx_done_s && (sel == 0);
  assign bus.i_rx_data  = rx_data_s;
  assign bus4.i_start   = start_s && (sel == 1);
  assign bus4.i_rx_done = rx_done_s && (sel == 1);
  assign bus4.i_rx_data = rx_data_s;

  instruction_memory_loader #(
    .MEM_SIZE(1024), .WORD_WIDTH(32), .ADDR_LENGTH(32), .BYTE_WIDTH(8), .HALT_WORD(HALT)
  ) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus)
  );

  instruction_memory_loader #(
    .MEM_SIZE(4), .WORD_WIDTH(32), .ADDR_LENGTH(32), .BYTE_WIDTH(8), .HALT_WORD(HALT)
  ) dut4 (
    .i_clk(clk), .i_reset(rst), .bus(bus4)
  );

  logic        cur_wr_en, cur_busy, cur_done, cur_full;
  logic [31:0] cur_addr, cur_data, cur_count;
  assign cur_wr_en = (sel == 1) ? bus4.o_wr_en      : bus.o_wr_en;
  assign cur_busy  = (sel == 1) ? bus4.o_busy       : bus.o_busy;
  assign cur_done  = (sel == 1) ? bus4.o_done       : bus.o_done;
  assign cur_full  = (sel == 1) ? bus4.o_full       : bus.o_full;
  assign cur_addr  = (sel == 1) ? bus4.o_wr_addr    : bus.o_wr_addr;
  assign cur_data  = (sel == 1) ? bus4.o_wr_data    : bus.o_wr_data;
  assign cur_count = (sel == 1) ? bus4.o_word_count : bus.o_word_count;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t        cap[$];
  wr_t        exp_q[$];
  logic [7:0] mbytes[$];
  logic       exp_full;
  int         exp_count;
  wr_t        mon_w;
  int         n_cmp = 0;
  int         n_err = 0;

  always @(negedge clk) begin
    if (cur_wr_en) begin
      mon_w.addr = cur_addr;
      mon_w.data = cur_data;
      mon_w.cyc  = cyc;
      cap.push_back(mon_w);
      $display("write dut=%0d addr=%0d data=%08h cycle=%0d", sel, cur_addr, cur_data, cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_done_s = 1'b1;
    rx_data_s = b;
    tick();
    rx_done_s = 1'b0;
  endtask

  task automatic pulse_start();
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
  endtask

  task automatic begin_load();
    cap.delete();
    mbytes.delete();
    pulse_start();
  endtask

  // Sends one word MSB first; the optional start pulse lands mid-word where it must be ignored.
  task automatic send_word(input logic [31:0] w, input int max_gap, input bit mid_start);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = w[31 - 8*i -: 8];
      send_byte(b);
      mbytes.push_back(b);
      if (i == 1 && mid_start) pulse_start();
      else idle($urandom_range(0, max_gap));
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    do w = $urandom; while (w == HALT);
    return w;
  endfunction

  // Reference: every 4 accepted bytes form one word at the next address; stop on halt or when full.
  task automatic build_expected(input int mem_size);
    wr_t         e;
    logic [31:0] w;
    exp_q.delete();
    exp_full  = 1'b0;
    exp_count = 0;
    for (int k = 0; 4*k + 3 < mbytes.size(); k++) begin
      w      = {mbytes[4*k], mbytes[4*k+1], mbytes[4*k+2], mbytes[4*k+3]};
      e.addr = 32'(k);
      e.data = w;
      e.cyc  = 0;
      exp_q.push_back(e);
      exp_count++;
      if (w == HALT) break;
      if (k == mem_size - 1) begin
        exp_full = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (cur_done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 64'(cur_done), 64'(1));
  endtask

  task automatic compare_writes(input string tag);
    int m;
    check({tag, "_nwrites"}, 64'(cap.size()), 64'(exp_q.size()));
    m = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(cap[i].addr), 64'(exp_q[i].addr));
      check($sformatf("%s_data%0d", tag, i), 64'(cap[i].data), 64'(exp_q[i].data));
    end
  endtask

  task automatic check_end(input string tag, input int mem_size);
    build_expected(mem_size);
    wait_done(tag);
    compare_writes(tag);
    check({tag, "_count"}, 64'(cur_count), 64'(exp_count));
    check({tag, "_full"},  64'(cur_full),  64'(exp_full));
    check({tag, "_busy"},  64'(cur_busy),  64'(0));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr_en"}, 64'(cur_wr_en), 64'(0));
    check({tag, "_addr"},  64'(cur_addr),  64'(0));
    check({tag, "_data"},  64'(cur_data),  64'(0));
    check({tag, "_busy"},  64'(cur_busy),  64'(0));
    check({tag, "_done"},  64'(cur_done),  64'(0));
    check({tag, "_full"},  64'(cur_full),  64'(0));
    check({tag, "_count"}, 64'(cur_count), 64'(0));
  endtask

  initial begin
    int nw;
    rst       = 1'b1;
    start_s   = 1'b0;
    rx_done_s = 1'b0;
    rx_data_s = 8'h00;
    sel       = 0;
    idle(3);
    rst = 1'b0;
    tick();
    check_zero("reset");

    // Bytes before any start are ignored.
    repeat (3) send_byte(8'($urandom));
    idle(2);
    check("idle_bytes_nowrite", 64'(cap.size()), 64'(0));

    // Example program followed by halt.
    begin_load();
    send_word(32'h2008_0005, 2, 1'b0);
    send_word(HALT, 2, 1'b0);
    check_end("basic", 1024);

    // Back-to-back bytes; each word's first byte arrives during the previous write cycle.
    begin_load();
    for (int i = 0; i < 3; i++) send_word(rand_word(), 0, 1'b0);
    send_word(HALT, 0, 1'b0);
    check_end("b2b", 1024);
    for (int i = 1; i < cap.size(); i++)
      check($sformatf("b2b_spacing%0d", i), 64'(cap[i].cyc - cap[i-1].cyc), 64'(4));

    // Bytes while DONE are discarded and nothing moves.
    repeat (4) send_byte(8'($urandom));
    idle(2);
    check("done_bytes_nowrite", 64'(cap.size()), 64'(exp_q.size()));
    check("done_bytes_count",   64'(cur_count),  64'(exp_count));
    check("done_bytes_done",    64'(cur_done),   64'(1));

    // A byte coinciding with start is not part of the program; restart clears the count.
    cap.delete();
    mbytes.delete();
    start_s   = 1'b1;
    rx_done_s = 1'b1;
    rx_data_s = 8'hAA;
    tick();
    start_s   = 1'b0;
    rx_done_s = 1'b0;
    check("restart_count", 64'(cur_count), 64'(0));
    check("restart_busy",  64'(cur_busy),  64'(1));
    check("restart_done",  64'(cur_done),  64'(0));
    send_word(rand_word(), 1, 1'b0);
    send_word(HALT, 1, 1'b0);
    check_end("start_byte", 1024);

    // Random programs with gaps and ignored start pulses mid-word.
    for (int t = 0; t < 4; t++) begin
      begin_load();
      nw = $urandom_range(1, 8);
      for (int i = 0; i < nw; i++) send_word(rand_word(), 3, 1'($urandom_range(0, 1)));
      send_word(HALT, 3, 1'b0);
      check_end($sformatf("rand%0d", t), 1024);
    end

    // Reset in the middle of a word leaves no trace.
    begin_load();
    send_byte(8'h12);
    send_byte(8'h34);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(2);
    check_zero("midrst");
    check("midrst_nowrite", 64'(cap.size()), 64'(0));
    begin_load();
    send_word(32'hCAFE_0001, 1, 1'b0);
    send_word(HALT, 1, 1'b0);
    check_end("after_rst", 1024);

    // Small memory: fills without a halt, extra bytes are dropped, restart clears full.
    sel = 1;
    begin_load();
    for (int i = 0; i < 4; i++) send_word(rand_word(), 1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      send_byte(b);
      mbytes.push_back(b);
    end
    idle(3);
    check_end("full", 4);
    pulse_start();
    check("full_restart_full",  64'(cur_full),  64'(0));
    check("full_restart_count", 64'(cur_count), 64'(0));
    sel = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
